uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Serial-to-parallel receiver placed directly downstream of the majority-vote line smoother in the communication module.
- Consumes the smoothed, already-synchronous serial bit.
- Detects start bits and samples each bit at mid-period.
- Presents each received byte on a valid/ready handshake, with framing- and overrun-error indications.

Parameters:
CLKS_PER_BIT, 16, CLK cycles per serial bit; legal range >= 4. H = CLKS_PER_BIT/2 (integer division).
DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9.

Ports:
CLK  in  1  system clock; all logic on posedge.
RST_N  in  1  asynchronous, active-low reset.
rx_in  in  1  smoothed serial line; idle level 1.
rx_data  out  DATA_BITS  received byte; stable while rx_valid is 1.
rx_valid  out  1  byte available; held until accepted.
rx_ready  in  1  consumer accepts the byte when rx_valid & rx_ready.
frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
overrun  out  1  one-cycle pulse: a completed frame was dropped because rx_valid was still 1.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - Single clock CLK; reset is asynchronous and active-low (RST_N).
  - While RST_N=0: state=IDLE, all counters 0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Asserting RST_N mid-frame aborts the frame and loses any pending byte.
- States: IDLE, START, DATA, STOP, WAIT_HIGH; PARITY only with the optional feature.
- IDLE:
  - First cycle with rx_in=0 is t0. At t0, enter START and clear the bit-timer.
- START:
  - At t0+H, sample rx_in.
  - rx_in=0: go to DATA and reload the timer.
  - rx_in=1: false start; return to IDLE with no outputs.
- DATA:
  - Data bit k (k=0..DATA_BITS-1) is sampled at t0+H+(k+1)*CLKS_PER_BIT.
  - Samples shift into a DATA_BITS-wide shift register, LSB first.
  - After the last bit, go to STOP.
- STOP:
  - Sampled at t0+H+(DATA_BITS+1)*CLKS_PER_BIT.
  - rx_in=1 and rx_valid=0: load rx_data; rx_valid=1 on the next cycle; go to IDLE.
  - rx_in=1 and rx_valid=1 (and not accepted that same cycle): drop the new byte; keep the old rx_data; pulse overrun; go to IDLE.
  - rx_in=1 and the old byte is accepted that same cycle: load the new byte with no overrun; rx_valid stays 1.
  - rx_in=0: pulse frame_err; discard the byte; go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_in=1, then go to IDLE. This prevents a break condition being read as start bits.
- Handshake:
  - rx_valid falls the cycle after rx_valid & rx_ready, unless a new byte loads in that same cycle.
  - rx_ready is ignored while rx_valid=0.
- Bit-timer: counts 0..CLKS_PER_BIT-1 and wraps. Width is $clog2(CLKS_PER_BIT). No overflow is possible.
- Bit counter: width $clog2(DATA_BITS+1). It saturates at DATA_BITS and is never wrapped.
- The next start bit may be detected on the cycle right after STOP exits. Back-to-back frames are supported.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Parameter PARITY_ODD (default 0 = even) is added, along with output parity_err (one-cycle pulse).
  - State PARITY is inserted after DATA. Its sample is taken at t0+H+(DATA_BITS+1)*CLKS_PER_BIT; STOP moves one bit period later.
  - On mismatch: pulse parity_err in the STOP-sample cycle; the byte is discarded (no rx_valid, no overrun).
- Undefined: no PARITY state and no parity_err port. Timing is as specified in Behaviour.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - default constants UART_CLKS_PER_BIT=16 and UART_DATA_BITS=8;
  - a function for even/odd parity.
- Sub-module uart_bit_timer(CLK, RST_N, clr, tick):
  - Free-running mod-CLKS_PER_BIT counter with synchronous clear.
  - Programmable first-tick offset: H for START, CLKS_PER_BIT afterwards.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8):
- Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop), rx_ready=1 → rx_data=0xA5; rx_valid high for exactly 1 cycle at t0+153; busy low from t0+153.
- rx_in low for 4 cycles then high → no rx_valid, no frame_err; busy drops at t0+9.
- Frame 0x3C with stop bit held 0 for 40 cycles → frame_err pulse at t0+152; no rx_valid; next frame 0x55 after the line returns high is received correctly.
- Two back-to-back frames 0x11, 0x22 with rx_ready=0 → rx_data stays 0x11; rx_valid stays 1; overrun pulses once. rx_ready=1 one cycle later → rx_valid falls.
- RST_N pulsed low at t0+70 during frame 0xFF → all outputs 0 immediately; no rx_valid afterwards; subsequent frame 0x81 is received correctly.
- UART_RX_PARITY_EN, even parity: frame 0x07 with parity bit 0 → parity_err pulse; no rx_valid. Same frame with parity bit 1 → rx_data=0x07 at t0+169.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// default frame geometry and a parity helper.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 16;
    localparam int unsigned UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Expected parity bit for up to 9 data bits (zero-extend narrower words).
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running mod-CLKS_PER_BIT bit timer.
// A synchronous clear preloads the counter so the first tick lands
// CLKS_PER_BIT/2 cycles later (mid start bit); after that it ticks
// every CLKS_PER_BIT cycles (mid data/stop bits).
// Ports:
//   CLK    system clock
//   RST_N  asynchronous active-low reset
//   clr    restart timing from the start-bit edge
//   tick   high in the cycle the line should be sampled
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned H  = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    // Preload so that H cycles after clr the counter reads LAST.
    localparam logic [CW-1:0] LOAD = CW'(CLKS_PER_BIT - H);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= LOAD;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start-bit detection, mid-bit sampling, LSB-first
// deserialisation and a valid/ready output with framing/overrun pulses.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN
// (adds parameter PARITY_ODD and output parity_err).
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   rx_in       smoothed serial line, idle high
//   rx_data     received word, stable while rx_valid
//   rx_valid    word available, held until rx_valid & rx_ready
//   rx_ready    consumer accept
//   frame_err   pulse in the stop-sample cycle when the stop bit is 0
//   overrun     pulse in the stop-sample cycle when a good word is dropped
//   parity_err  (optional) pulse in the stop-sample cycle on parity mismatch
//   busy        high whenever the receiver is not idle
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD   = 1'b0
`endif
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] FULL     = BW'(DATA_BITS);

    rx_state_t            state, state_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic [DATA_BITS-1:0] rx_data_d;
    logic [BW-1:0]        bit_cnt, bit_cnt_d;
    logic                 rx_valid_d;
    logic                 tick;
    logic                 timer_clr;
    logic                 accept;
    logic                 word_ok;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, par_bad_d;
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .CLK  (CLK),
        .RST_N(RST_N),
        .clr  (timer_clr),
        .tick (tick)
    );

    assign accept = rx_valid & rx_ready;
    assign busy   = (state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign word_ok = ~par_bad;
`else
    assign word_ok = 1'b1;
`endif

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            bit_cnt  <= bit_cnt_d;
            rx_data  <= rx_data_d;
            rx_valid <= rx_valid_d;
`ifdef UART_RX_PARITY_EN
            par_bad  <= par_bad_d;
`endif
        end
    end

    // Next-state, datapath update and sample-cycle pulses.
    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        bit_cnt_d  = bit_cnt;
        rx_data_d  = rx_data;
        rx_valid_d = rx_valid;
        timer_clr  = 1'b0;
        frame_err  = 1'b0;
        overrun    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad;
        parity_err = 1'b0;
`endif

        if (accept) begin
            rx_valid_d = 1'b0;
        end

        case (state)
            IDLE: begin
                if (!rx_in) begin
                    state_d   = START;
                    timer_clr = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_in) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d = {rx_in, shreg[DATA_BITS-1:1]};
                    if (bit_cnt != FULL) begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_bad_d = (rx_in != parity_bit(9'(shreg), PARITY_ODD));
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
`ifdef UART_RX_PARITY_EN
                    parity_err = par_bad;
`endif
                    if (!rx_in) begin
                        frame_err = 1'b1;
                        state_d   = WAIT_HIGH;
                    end else begin
                        state_d = IDLE;
                        if (word_ok) begin
                            // A word accepted this same cycle frees the slot.
                            if (!rx_valid || accept) begin
                                rx_data_d  = shreg;
                                rx_valid_d = 1'b1;
                            end else begin
                                overrun = 1'b1;
                            end
                        end
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line recovers so a break is not seen as starts.
                if (rx_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame (CLKS_PER_BIT=16, DATA_BITS=8).
// Expected words are queued as frames are sent and compared on acceptance.
module tb_uart_rx_frame;

    logic       CLK;
    logic       RST_N;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_frame #(
        .CLKS_PER_BIT(16),
        .DATA_BITS   (8)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         errors;
    int         checks;
    int         cyc;
    logic       rdy;
    logic [7:0] exp_q[$];

    // Per-test event record filled by the monitor.
    int valid_cycles;
    int first_valid;
    int fe_cnt;
    int fe_cyc;
    int ov_cnt;
    int ov_cyc;
    int pe_cnt;
    int pe_cyc;
    int busy_fall;
    logic prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_rec();
        valid_cycles = 0;
        first_valid  = -1;
        fe_cnt       = 0;
        fe_cyc       = -1;
        ov_cnt       = 0;
        ov_cyc       = -1;
        pe_cnt       = 0;
        pe_cyc       = -1;
        busy_fall    = -1;
    endtask

    task automatic mon();
        if (rx_valid) begin
            valid_cycles++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (rx_valid && rx_ready) begin
            chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        if (frame_err) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        if (overrun) begin
            ov_cnt++;
            ov_cyc = cyc;
        end
`ifdef UART_RX_PARITY_EN
        if (parity_err) begin
            pe_cnt++;
            pe_cyc = cyc;
        end
`endif
        if (prev_busy && !busy) busy_fall = cyc;
        prev_busy = busy;
    endtask

    // One clock cycle: drive inputs shortly after the edge, sample at mid-cycle.
    task automatic drive(input logic rx);
        @(posedge CLK);
        cyc++;
        #2;
        rx_in    = rx;
        rx_ready = rdy;
        #3;
        mon();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input logic stop_bit,
                              input int stop_len, output int t0);
        t0 = cyc + 1;
        for (int i = 0; i < 16; i++) drive(1'b0);
        for (int b = 0; b < nb; b++)
            for (int i = 0; i < 16; i++) drive(d[b]);
        for (int i = 0; i < stop_len; i++) drive(stop_bit);
    endtask

    int t0;
    int t1;

    initial begin
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        rdy       = 1'b0;
        prev_busy = 1'b0;
        rx_in     = 1'b1;
        rx_ready  = 1'b0;
        RST_N     = 1'b1;
        clr_rec();

        // Reset values
        #1 RST_N = 1'b0;
        #2;
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        idle(3);
        RST_N = 1'b1;
        idle(5);

        // Frame 0xA5, consumer always ready
        rdy = 1'b1;
        idle(1);
        clr_rec();
        exp_q.push_back(8'hA5);
        send_frame(9'h0A5, 8, 1'b1, 16, t0);
        idle(10);
        chk("a5_valid_cycle", 32'(first_valid), 32'(t0 + 153));
        chk("a5_valid_len", 32'(valid_cycles), 32'd1);
        chk("a5_busy_fall", 32'(busy_fall), 32'(t0 + 153));
        chk("a5_no_frame_err", 32'(fe_cnt), 32'd0);
        chk("a5_queue_empty", 32'(exp_q.size()), 32'd0);

        // False start: 4 low cycles
        clr_rec();
        t0 = cyc + 1;
        for (int i = 0; i < 4; i++) drive(1'b0);
        idle(20);
        chk("fs_busy_fall", 32'(busy_fall), 32'(t0 + 9));
        chk("fs_no_valid", 32'(valid_cycles), 32'd0);
        chk("fs_no_frame_err", 32'(fe_cnt), 32'd0);

        // Frame 0x3C with stop held low for 40 cycles, then 0x55
        clr_rec();
        send_frame(9'h03C, 8, 1'b0, 40, t0);
        idle(5);
        chk("fe_count", 32'(fe_cnt), 32'd1);
        chk("fe_cycle", 32'(fe_cyc), 32'(t0 + 152));
        chk("fe_no_valid", 32'(valid_cycles), 32'd0);
        clr_rec();
        exp_q.push_back(8'h55);
        send_frame(9'h055, 8, 1'b1, 16, t0);
        idle(5);
        chk("fe_next_valid_len", 32'(valid_cycles), 32'd1);
        chk("fe_next_queue_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back 0x11, 0x22 with consumer stalled: second frame overruns
        rdy = 1'b0;
        idle(1);
        clr_rec();
        exp_q.push_back(8'h11);
        send_frame(9'h011, 8, 1'b1, 16, t0);
        send_frame(9'h022, 8, 1'b1, 16, t1);
        idle(5);
        chk("ov_rx_data_kept", 32'(rx_data), 32'h11);
        chk("ov_rx_valid_held", 32'(rx_valid), 32'd1);
        chk("ov_count", 32'(ov_cnt), 32'd1);
        chk("ov_cycle", 32'(ov_cyc), 32'(t1 + 152));
        chk("ov_pending", 32'(exp_q.size()), 32'd1);
        rdy = 1'b1;
        idle(1);
        idle(1);
        chk("ov_valid_fell", 32'(rx_valid), 32'd0);
        chk("ov_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset pulse at t0+70 of frame 0xFF, then 0x81
        clr_rec();
        t0 = cyc + 1;
        for (int i = 0; i < 16; i++) drive(1'b0);
        while (cyc < t0 + 70) drive(1'b1);
        chk("rst_mid_busy_before", 32'(busy), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rx_data", 32'(rx_data), 32'd0);
        chk("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
        #2 RST_N = 1'b1;
        while (cyc < t0 + 160) drive(1'b1);
        idle(20);
        chk("rst_mid_no_valid", 32'(valid_cycles), 32'd0);
        clr_rec();
        exp_q.push_back(8'h81);
        send_frame(9'h081, 8, 1'b1, 16, t0);
        idle(5);
        chk("post_rst_valid_cycle", 32'(first_valid), 32'(t0 + 153));
        chk("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        clr_rec();
        send_frame({1'b0, 8'h07}, 9, 1'b1, 16, t0);
        idle(5);
        chk("par_bad_count", 32'(pe_cnt), 32'd1);
        chk("par_bad_cycle", 32'(pe_cyc), 32'(t0 + 168));
        chk("par_bad_no_valid", 32'(valid_cycles), 32'd0);
        chk("par_bad_no_overrun", 32'(ov_cnt), 32'd0);
        clr_rec();
        exp_q.push_back(8'h07);
        send_frame({1'b1, 8'h07}, 9, 1'b1, 16, t0);
        idle(5);
        chk("par_ok_valid_cycle", 32'(first_valid), 32'(t0 + 169));
        chk("par_ok_no_err", 32'(pe_cnt), 32'd0);
        chk("par_ok_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
